access_rqst_sched: RTL
======================

ACCESS_RQST_SCHED -- requirements
Module: access_rqst_sched

Interface
REQ-001 SHALL have parameter SHARED_BANK_NUM, default 5, number of requestors in the share group.
REQ-002 SHALL have parameter RQST_ADDR_BITWIDTH, default 3, column-address width per requestor.
REQ-003 SHALL derive COL_NUM = 2**RQST_ADDR_BITWIDTH, which is the number of column banks.
REQ-004 SHALL have parameter GRANT_PER_CYCLE, default 2, maximum number of grants per beat (range 1..SHARED_BANK_NUM).
REQ-005 SHALL have parameter [COL_NUM-1:0] DEFAULT_COL_MASK, default all-ones, which is the shared-column mask after reset.
REQ-006 SHALL have port sys_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port cfg_we_i, input, 1, shared-column mask write strobe.
REQ-009 SHALL have port cfg_colMask_i, input, COL_NUM, new mask; bit c = '1' means column c is in shared group 2.
REQ-010 SHALL have port rqst_valid_i, input, 1, request batch valid.
REQ-011 SHALL have port rqst_ready_o, output, 1, batch accept ready.
REQ-012 SHALL have port rqst_addr_i, input, RQST_ADDR_BITWIDTH*SHARED_BANK_NUM, concatenated column addresses with requestor i at slice [(i+1)*W-1 : i*W].
REQ-013 SHALL have port share_rqstFlag_o, output, SHARED_BANK_NUM, registered request flags of the batch currently being processed.
REQ-014 SHALL have port grant_valid_o, output, 1, grant beat valid.
REQ-015 SHALL have port grant_ready_i, input, 1, downstream accepts the grant beat.
REQ-016 SHALL have port grant_o, output, SHARED_BANK_NUM, requestors granted in this beat.
REQ-017 SHALL have port grant_last_o, output, 1, final beat of the batch.
REQ-018 SHALL have port busy_o, output, 1, high while a batch is in progress.

Function
REQ-019 SHALL hold a COL_NUM-bit mask register that is written from cfg_colMask_i on cfg_we_i only in IDLE; cfg_we_i SHALL be ignored in GRANT.
REQ-020 SHALL implement the FSM states IDLE and GRANT; rqst_ready_o = (state==IDLE); busy_o = (state==GRANT).
REQ-021 SHALL accept a batch on rqst_valid_i && rqst_ready_o, then register flag[i] = mask[rqst_addr[i]] into share_rqstFlag_o and a pending vector, and enter GRANT.
REQ-022 SHALL compute flags on simultaneous cfg_we_i and batch acceptance using the mask value held before that edge; the new mask SHALL apply from the next batch.
REQ-023 SHALL assert grant_valid_o in every GRANT cycle, with the first beat in the cycle after acceptance (1-cycle latency).
REQ-024 SHALL form grant_o from the lowest-indexed set bits of pending, up to GRANT_PER_CYCLE bits.
REQ-025 SHALL assert grant_last_o when pending has no set bits beyond those in grant_o.
REQ-026 SHALL hold grant_o, grant_last_o and pending stable while grant_valid_o && !grant_ready_i.
REQ-027 SHALL clear the grant_o bits from pending on grant_valid_o && grant_ready_i; if grant_last_o was set, the FSM SHALL return to IDLE at that same edge.
REQ-028 SHALL, for an all-zero flag batch, emit exactly one beat with grant_o=0 and grant_last_o=1.
REQ-029 SHALL issue max(1, ceil(popcount(flags)/GRANT_PER_CYCLE)) beats per batch.
REQ-030 SHALL keep share_rqstFlag_o unchanged until the next batch is accepted.
REQ-031 SHALL NOT accept a new batch in the cycle of the last handshake; acceptance is possible from the following IDLE cycle.

Reset
REQ-032 SHALL, on rst high at a clock edge, set: state to IDLE, the mask to DEFAULT_COL_MASK, pending to 0, share_rqstFlag_o to 0, grant_o to 0, grant_valid_o to 0, grant_last_o to 0 and busy_o to 0.
REQ-033 SHALL have rqst_ready_o = 1 in the first cycle after rst deasserts.
REQ-034 SHALL make rst asserted mid-batch abort the batch with no further grant beats, and SHALL make it discard the pending state.
REQ-035 SHALL give rst priority over cfg_we_i and rqst_valid_i in the same cycle.

Verification
REQ-036 Bench SHALL cover: mask 8'b01010101, addresses req0..req4 = 0,1,2,3,4, grant_ready_i=1 -> share_rqstFlag_o=5'b10101; beat1 grant_o=5'b00101 last=0; beat2 grant_o=5'b10000 last=1; then IDLE.
REQ-037 Bench SHALL cover: same stimulus with grant_ready_i low for 3 cycles on beat1 -> grant_o stays 5'b00101 for 4 cycles and no new batch is accepted.
REQ-038 Bench SHALL cover: mask 8'b11110000, all addresses 1 -> flags 0, one beat grant_o=0 last=1.
REQ-039 Bench SHALL cover: cfg_we_i with mask 8'h00 in the same cycle as acceptance under mask 8'hFF -> flags 5'b11111 (3 beats: 00011, 01100, 10000); the next batch yields flags 0.
REQ-040 Bench SHALL cover: cfg_we_i during GRANT -> mask unchanged (read back via the following batch's flags).
REQ-041 Bench SHALL cover: rst asserted during beat2 -> the next cycle has grant_valid_o=0, share_rqstFlag_o=0, rqst_ready_o=1, and the mask equals DEFAULT_COL_MASK.

Source files
------------

// File: rtl/access_rqst_sched.sv
// Shared-bank access scheduler: flags each requestor whose column falls in the
// shared mask, then drains the flagged set in beats of up to GRANT_PER_CYCLE grants.
//   state    | meaning
//   ST_IDLE  | ready for a batch; mask writes accepted
//   ST_GRANT | presenting grant beats until the last one is taken
module access_rqst_sched #(
    parameter int SHARED_BANK_NUM    = 5,
    parameter int RQST_ADDR_BITWIDTH = 3,
    parameter int GRANT_PER_CYCLE    = 2,
    localparam int COL_NUM           = 2**RQST_ADDR_BITWIDTH,
    parameter logic [COL_NUM-1:0] DEFAULT_COL_MASK = '1
) (
    input  logic                                        sys_clk,
    input  logic                                        rst,
    input  logic                                        cfg_we_i,
    input  logic [COL_NUM-1:0]                          cfg_colMask_i,
    input  logic                                        rqst_valid_i,
    output logic                                        rqst_ready_o,
    input  logic [RQST_ADDR_BITWIDTH*SHARED_BANK_NUM-1:0] rqst_addr_i,
    output logic [SHARED_BANK_NUM-1:0]                  share_rqstFlag_o,
    output logic                                        grant_valid_o,
    input  logic                                        grant_ready_i,
    output logic [SHARED_BANK_NUM-1:0]                  grant_o,
    output logic                                        grant_last_o,
    output logic                                        busy_o
);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t                     r_state;
    logic [COL_NUM-1:0]         r_mask;
    logic [SHARED_BANK_NUM-1:0] r_pending;

    logic [SHARED_BANK_NUM-1:0] w_flags;
    logic [SHARED_BANK_NUM-1:0] w_acc_grant;
    logic                       w_acc_last;
    logic [SHARED_BANK_NUM-1:0] w_pend_nxt;
    logic [SHARED_BANK_NUM-1:0] w_nxt_grant;
    logic                       w_nxt_last;

    // Keep the lowest-indexed set bits, at most GRANT_PER_CYCLE of them.
    function automatic logic [SHARED_BANK_NUM-1:0] f_low_bits(input logic [SHARED_BANK_NUM-1:0] vec);
        int cnt;
        cnt = 0;
        f_low_bits = '0;
        for (int i = 0; i < SHARED_BANK_NUM; i++) begin
            if (vec[i] && (cnt < GRANT_PER_CYCLE)) begin
                f_low_bits[i] = 1'b1;
                cnt++;
            end
        end
    endfunction

    always_comb begin
        w_flags = '0;
        for (int i = 0; i < SHARED_BANK_NUM; i++) begin
            w_flags[i] = r_mask[rqst_addr_i[i*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH]];
        end
    end

    assign w_acc_grant = f_low_bits(w_flags);
    assign w_acc_last  = ((w_flags & ~w_acc_grant) == '0);
    assign w_pend_nxt  = r_pending & ~grant_o;
    assign w_nxt_grant = f_low_bits(w_pend_nxt);
    assign w_nxt_last  = ((w_pend_nxt & ~w_nxt_grant) == '0);

    assign rqst_ready_o = (r_state == ST_IDLE);
    assign busy_o       = (r_state == ST_GRANT);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_mask           <= DEFAULT_COL_MASK;
            r_pending        <= '0;
            share_rqstFlag_o <= '0;
            grant_o          <= '0;
            grant_valid_o    <= 1'b0;
            grant_last_o     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_we_i) begin
                        r_mask <= cfg_colMask_i;
                    end
                    // Flags use the mask held before this edge, even if it is being rewritten.
                    if (rqst_valid_i) begin
                        share_rqstFlag_o <= w_flags;
                        r_pending        <= w_flags;
                        grant_o          <= w_acc_grant;
                        grant_last_o     <= w_acc_last;
                        grant_valid_o    <= 1'b1;
                        r_state          <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (grant_ready_i) begin
                        if (grant_last_o) begin
                            r_pending     <= '0;
                            grant_o       <= '0;
                            grant_last_o  <= 1'b0;
                            grant_valid_o <= 1'b0;
                            r_state       <= ST_IDLE;
                        end else begin
                            r_pending    <= w_pend_nxt;
                            grant_o      <= w_nxt_grant;
                            grant_last_o <= w_nxt_last;
                        end
                    end
                end
            endcase
        end
    end

endmodule
